// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for eight common-anode 7-segment digits.
// The word, point and blank masks are shadowed at frame wrap so no digit tears.
module seg7_scan_driver #(
  parameter int SCAN_PERIOD = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data,
  input  logic [7:0]  point,
  input  logic [7:0]  le,
  input  logic        load_now,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int CNT_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SCAN_PERIOD - 1);

  logic [CNT_W-1:0] r_tick;
  logic [2:0]       r_digit;
  logic             r_frame_done;
  logic [31:0]      r_sh_data;
  logic [7:0]       r_sh_point;
  logic [7:0]       r_sh_le;
  logic [7:0]       r_an;
  logic [7:0]       r_seg;

  logic             w_tc;
  logic             w_wrap;
  logic [3:0]       w_nib;
  logic [7:0]       w_an;
  logic [7:0]       w_seg;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] c;
    case (v)
      4'h0: c = 7'h40;
      4'h1: c = 7'h79;
      4'h2: c = 7'h24;
      4'h3: c = 7'h30;
      4'h4: c = 7'h19;
      4'h5: c = 7'h12;
      4'h6: c = 7'h02;
      4'h7: c = 7'h78;
      4'h8: c = 7'h00;
      4'h9: c = 7'h10;
      4'hA: c = 7'h08;
      4'hB: c = 7'h03;
      4'hC: c = 7'h46;
      4'hD: c = 7'h21;
      4'hE: c = 7'h06;
      default: c = 7'h0E;
    endcase
    return c;
  endfunction

  assign w_tc   = (r_tick == TC_VAL);
  assign w_wrap = w_tc && (r_digit == 3'd7);

  // Scan timing: dwell counter, digit index and frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick       <= '0;
      r_digit      <= 3'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_tick       <= w_tc ? '0 : r_tick + CNT_W'(1);
      r_frame_done <= w_wrap;
      if (w_tc) begin
        r_digit <= r_digit + 3'd1;
      end
    end
  end

  // Shadow capture: wrap and load_now collapse into one load of the same inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_data  <= '0;
      r_sh_point <= '0;
      r_sh_le    <= '0;
    end else if (w_wrap || load_now) begin
      r_sh_data  <= disp_data;
      r_sh_point <= point;
      r_sh_le    <= le;
    end
  end

  always_comb begin
    w_nib = r_sh_data[{r_digit, 2'b00} +: 4];
    w_an  = ~(8'b1 << r_digit);
    w_seg = {~r_sh_point[r_digit], hex7(w_nib)};
    if (r_sh_le[r_digit]) begin
      w_an  = 8'hFF;
      w_seg = 8'hFF;
    end
  end

  // Output register stage: decode lags the digit index by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 8'hFF;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign digit_idx  = r_digit;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_PERIOD = 4.
// Expected per-cycle outputs are queued up front; a monitor pops and compares each cycle.
module tb_seg7_scan_driver;

  localparam int SP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] disp_data = '0;
  logic [7:0]  point = '0;
  logic [7:0]  le = '0;
  logic        load_now = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [2:0]  digit_idx;
  logic        frame_done;

  seg7_scan_driver #(.SCAN_PERIOD(SP)) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_data  (disp_data),
    .point      (point),
    .le         (le),
    .load_now   (load_now),
    .an         (an),
    .seg        (seg),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int R = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [7:0] seg;
    logic [2:0] idx;
    logic       fd;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] c;
    case (v)
      4'h0: c = 8'hC0;
      4'h1: c = 8'hF9;
      4'h2: c = 8'hA4;
      4'h3: c = 8'hB0;
      4'h4: c = 8'h99;
      4'h5: c = 8'h92;
      4'h6: c = 8'h82;
      4'h7: c = 8'hF8;
      4'h8: c = 8'h80;
      4'h9: c = 8'h90;
      4'hA: c = 8'h88;
      4'hB: c = 8'h83;
      4'hC: c = 8'hC6;
      4'hD: c = 8'hA1;
      4'hE: c = 8'h86;
      default: c = 8'h8E;
    endcase
    return c;
  endfunction

  // n counts clock edges since reset release; outputs after edge n show the digit scanned before it
  function automatic void push_n(int n, logic [31:0] d, logic [7:0] pt, logic [7:0] bl, string nm);
    exp_t e;
    int dig;
    logic [3:0] nib;
    logic [7:0] s;
    dig = ((n - 1) / SP) % 8;
    nib = d[4*dig +: 4];
    s = hex7(nib);
    s[7] = ~pt[dig];
    e.cyc = R + n;
    if (bl[dig]) begin
      e.an  = 8'hFF;
      e.seg = 8'hFF;
    end else begin
      e.an  = ~(8'h01 << dig);
      e.seg = s;
    end
    e.idx = 3'((n / SP) % 8);
    e.fd  = ((n % (8 * SP)) == 0);
    e.nm  = nm;
    q.push_back(e);
  endfunction

  function automatic void push_range(int lo, int hi, logic [31:0] d, logic [7:0] pt, logic [7:0] bl, string nm);
    for (int n = lo; n <= hi; n++) push_n(n, d, pt, bl, nm);
  endfunction

  task automatic check(string nm, int cyc, logic [7:0] a, logic [7:0] ea, logic [7:0] s, logic [7:0] es,
                       logic [2:0] i, logic [2:0] ei, logic f, logic ef);
    n_chk++;
    if (a !== ea || s !== es || i !== ei || f !== ef) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got an=%h seg=%h idx=%0d fd=%b, expected an=%h seg=%h idx=%0d fd=%b",
               nm, cyc, a, s, i, f, ea, es, ei, ef);
    end
  endtask

  task automatic goto(int n);
    while (ecnt < R + n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    while (q.size() > 0 && q[0].cyc <= ecnt) begin
      mon_e = q.pop_front();
      if (mon_e.cyc < ecnt) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s missed cyc=%0d now=%0d", mon_e.nm, mon_e.cyc, ecnt);
      end else begin
        check(mon_e.nm, mon_e.cyc - R, an, mon_e.an, seg, mon_e.seg, digit_idx, mon_e.idx,
              frame_done, mon_e.fd);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hold", 0, an, 8'hFF, seg, 8'hFF, digit_idx, 3'd0, frame_done, 1'b0);
    rst = 1'b0;
    R = ecnt;
    check("rel_pre_edge", 0, an, 8'hFF, seg, 8'hFF, digit_idx, 3'd0, frame_done, 1'b0);

    push_range(2,   62,  32'h0,        8'h00, 8'h00, "zero_scan");
    push_range(63,  96,  32'h89ABCDEF, 8'h00, 8'h00, "load_89AB");
    push_range(97,  128, 32'h01234567, 8'h00, 8'h00, "no_tear");
    push_range(129, 170, 32'hFFFFFFFF, 8'h00, 8'h00, "after_wrap_F");
    push_range(171, 224, 32'h76543210, 8'h01, 8'h80, "point_blank");
    push_range(225, 277, 32'hC0FFEE12, 8'h00, 8'h00, "load_on_wrap");

    goto(61);
    disp_data = 32'h89ABCDEF;
    load_now  = 1'b1;
    goto(62);
    load_now  = 1'b0;
    goto(95);
    disp_data = 32'h01234567;
    goto(108);
    disp_data = 32'hFFFFFFFF;
    goto(169);
    disp_data = 32'h76543210;
    point     = 8'h01;
    le        = 8'h80;
    load_now  = 1'b1;
    goto(170);
    load_now  = 1'b0;
    goto(223);
    disp_data = 32'hC0FFEE12;
    point     = 8'h00;
    le        = 8'h00;
    load_now  = 1'b1;
    goto(224);
    load_now  = 1'b0;

    goto(277);
    #1 rst = 1'b1;
    #1 check("async_rst", 277, an, 8'hFF, seg, 8'hFF, digit_idx, 3'd0, frame_done, 1'b0);
    disp_data = 32'hFFFFFFFF;
    point     = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_hold2", 0, an, 8'hFF, seg, 8'hFF, digit_idx, 3'd0, frame_done, 1'b0);
    rst = 1'b0;
    R = ecnt;
    check("rel2_pre_edge", 0, an, 8'hFF, seg, 8'hFF, digit_idx, 3'd0, frame_done, 1'b0);
    push_range(2, 32, 32'h0, 8'h00, 8'h00, "shadow_cleared");

    goto(34);
    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s never_checked cyc=%0d", mon_e.nm, mon_e.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
